// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 4-bit adder among NUM_REQ requesters.
// Define ADDER_ARBITER_TXN_CNT_EN to add the saturating o_txn_count response counter.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    output logic [NUM_REQ-1:0]   o_req_ready,
    input  logic [4*NUM_REQ-1:0] i_req_a,
    input  logic [4*NUM_REQ-1:0] i_req_b,
    output logic [3:0]           o_add_a,
    output logic [3:0]           o_add_b,
    input  logic [4:0]           i_add_y,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [ID_W-1:0]      o_rsp_id,
    output logic [4:0]           o_rsp_sum
`ifdef ADDER_ARBITER_TXN_CNT_EN
    ,
    output logic [15:0]          o_txn_count
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t          r_state;
    logic [ID_W-1:0] r_rr_ptr, r_id_q, r_rsp_id, w_grant;
    logic [3:0]      r_op_a, r_op_b;
    logic [4:0]      r_rsp_sum;
    logic            r_rsp_valid, w_any;
    always_comb begin
        w_grant = '0;
        w_any   = |i_req_valid;
        // descending offset so the requester closest to r_rr_ptr wins
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (i_req_valid[(int'(r_rr_ptr) + k) % NUM_REQ])
                w_grant = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
    end
    assign o_req_ready = (rst_n && r_state == IDLE && w_any) ? (NUM_REQ'(1) << w_grant) : '0;
    assign o_add_a     = r_op_a;
    assign o_add_b     = r_op_b;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_sum   = r_rsp_sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_id_q      <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_op_a   <= i_req_a[int'(w_grant)*4 +: 4];
                    r_op_b   <= i_req_b[int'(w_grant)*4 +: 4];
                    r_id_q   <= w_grant;
                    r_rr_ptr <= ID_W'((int'(w_grant) + 1) % NUM_REQ);
                    r_state  <= ISSUE;
                end
                ISSUE: begin
                    r_rsp_sum   <= i_add_y;
                    r_rsp_id    <= r_id_q;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: if (i_rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`ifdef ADDER_ARBITER_TXN_CNT_EN
    logic [15:0] r_txn_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_txn_count <= '0;
        else if (r_rsp_valid && i_rsp_ready && r_txn_count != 16'hFFFF)
            r_txn_count <= r_txn_count + 16'd1;
    end
    assign o_txn_count = r_txn_count;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: randomized requesters and response backpressure checked against a transaction-level model.
module tb_adder_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_ready;
    logic [4*N-1:0] req_a, req_b;
    logic [3:0]     add_a, add_b;
    logic [4:0]     add_y;
    logic           rsp_valid, rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [4:0]     rsp_sum;
`ifdef ADDER_ARBITER_TXN_CNT_EN
    logic [15:0]    txn_count;
`endif
    assign add_y = {1'b0, add_a} + {1'b0, add_b};
    always #5 clk = ~clk;
    adder_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b),
        .o_add_a(add_a), .o_add_b(add_b), .i_add_y(add_y),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_sum(rsp_sum)
`ifdef ADDER_ARBITER_TXN_CNT_EN
        , .o_txn_count(txn_count)
`endif
    );
    int n_checks = 0, n_fail = 0;
    bit pend[N];
    int pa[N], pb[N];
    int m_ptr, m_age, m_txn, e_id, e_a, e_b;
    bit m_busy;
    int p_new, p_drop, p_ready, p_rst;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    function automatic int rnd_op();
        case ($urandom_range(3))
            0: return 0;
            1: return 15;
            default: return int'($urandom_range(15));
        endcase
    endfunction
    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < p_new) begin
                pend[i] = 1'b1;
                pa[i] = rnd_op();
                pb[i] = rnd_op();
            end else if (pend[i] && int'($urandom_range(99)) < p_drop)
                pend[i] = 1'b0;
            req_valid[i]     = pend[i];
            req_a[i*4 +: 4]  = pend[i] ? 4'(pa[i]) : 4'($urandom_range(15));
            req_b[i*4 +: 4]  = pend[i] ? 4'(pb[i]) : 4'($urandom_range(15));
        end
        rsp_ready = int'($urandom_range(99)) < p_ready;
    endtask
    task automatic step();
        int g;
        @(negedge clk);
        rst_n = 1'b1;
        drive();
        #1;
        g = m_busy ? -1 : pick();
        check("req_ready", req_ready, g < 0 ? 0 : (1 << g));
        check("rsp_valid", rsp_valid, m_busy && m_age >= 2);
        if (m_busy && m_age >= 2) begin
            check("rsp_id", rsp_id, e_id);
            check("rsp_sum", rsp_sum, e_a + e_b);
        end
        if (m_busy && m_age == 1)
            check("add_ab", {add_a, add_b}, (e_a << 4) | e_b);
`ifdef ADDER_ARBITER_TXN_CNT_EN
        check("txn_count", txn_count, m_txn);
`endif
        if (m_busy && m_age == 1 && int'($urandom_range(99)) < p_rst) begin
            rst_n = 1'b0;
            #1;
            m_busy = 0;
            m_ptr  = 0;
            m_txn  = 0;
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_outs", {add_a, add_b, rsp_sum, rsp_id}, 0);
            return;
        end
        if (g >= 0) begin
            m_busy = 1;
            m_age  = 1;
            e_id   = g;
            e_a    = pa[g];
            e_b    = pb[g];
            m_ptr  = (g + 1) % N;
            pend[g] = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 2 && rsp_ready) begin
                m_busy = 0;
                if (m_txn < 65535) m_txn++;
            end else
                m_age++;
        end
    endtask
    initial begin
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        m_ptr = 0; m_busy = 0; m_age = 0; m_txn = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_outs", {add_a, add_b, rsp_sum, rsp_id}, 0);
`ifdef ADDER_ARBITER_TXN_CNT_EN
        check("reset_txn_count", txn_count, 0);
`endif
        req_valid = '0;
        pa = '{3, 15, 0, 7};
        pb = '{5, 15, 0, 9};
        pend = '{1, 1, 1, 1};
        p_new = 0; p_drop = 0; p_ready = 100; p_rst = 0;
        repeat (16) step();
        p_new = 30; p_drop = 5; p_ready = 70; p_rst = 5;
        repeat (3000) step();
        p_rst = 0; p_drop = 0; p_ready = 100;
        repeat (20) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin scheduler that shares one 4-bit adder datapath (operands a/b, 5-bit sum y) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester, drives the adder's operand inputs, captures the sum and returns it with the requester ID on a valid/ready response channel.
- Sits between client blocks and the adder datapath instance in the adder subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of the requester ID

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_a  input  4*NUM_REQ  operand a; requester i occupies bits [4i+3:4i]
- req_b  input  4*NUM_REQ  operand b, same packing as req_a
- add_a  output  4  operand a to the shared adder
- add_b  output  4  operand b to the shared adder
- add_y  input  5  sum from the shared adder, combinational from add_a/add_b
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  ID_W  ID of the requester the response belongs to
- rsp_sum  output  5  registered sum

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0.
  - Operand registers, add_a, add_b, rsp_sum and rsp_id are all 0.
  - rsp_valid=0, req_ready=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - req_ready = one-hot(grant), combinational, asserted only in IDLE and only when some req_valid is set.
  - On a handshake (valid & ready): capture req_a/req_b slice into op_a/op_b, capture grant into id_q, set rr_ptr = (grant+1) mod NUM_REQ, go to ISSUE.
  - If no request is valid: stay in IDLE; rr_ptr unchanged.
- ISSUE:
  - add_a=op_a, add_b=op_b (add_a/add_b are always driven from op_a/op_b in every state).
  - At the clock edge: rsp_sum<=add_y, rsp_id<=id_q, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid held at 1; rsp_sum and rsp_id held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE.
  - req_ready=0 throughout RESP.
- Timing:
  - Latency: handshake in cycle T gives rsp_valid=1 at T+2.
  - Peak throughput: one transaction per 3 cycles when rsp_ready is held at 1.
- Width rules:
  - The sum is 5 bits and always carries the full unsigned result; no overflow is possible (max 15+15=30).
  - rsp_sum = zero-extended a + zero-extended b.
- Boundary conditions:
  - Requester whose req_valid drops before being granted: no side effects. Requesters must hold req_valid and operands stable until ready.
  - req_valid asserted for rr_ptr and others at the same time: rr_ptr wins.
  - rr_ptr at NUM_REQ-1 wraps to 0 after a grant.
  - Reset asserted in ISSUE or RESP: the transaction is discarded, no response is issued, and all state returns to reset values immediately.
  - A new request arriving during ISSUE/RESP waits; it is considered in the first IDLE cycle after the response handshake.

Optional Feature:
- Macro: ADDER_ARBITER_TXN_CNT_EN.
- Defined:
  - Adds output port txn_count, 16 bits, reset 0.
  - Increments by 1 on every response handshake (rsp_valid & rsp_ready).
  - Saturates at 16'hFFFF.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req_valid[2]=1, a=3, b=5, rsp_ready=1 -> req_ready[2] pulses in cycle T; rsp_valid at T+2 with rsp_id=2, rsp_sum=8; back in IDLE at T+3.
- All four requesters valid from reset, rsp_ready=1 -> grants in order 0,1,2,3,0; each response carries the matching ID and sum; responses are 3 cycles apart.
- Max operands: a=15, b=15 -> rsp_sum=30 (5'b11110); a=0, b=0 -> rsp_sum=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_sum stay stable; req_ready stays 0; when rsp_ready=1 the next grant follows one cycle later.
- Reset mid-operation: rst_n low during ISSUE -> rsp_valid=0 and rr_ptr=0 immediately; no response issued after release; requester 0 is granted first after release.
- With ADDER_ARBITER_TXN_CNT_EN defined: 10 transactions -> txn_count=10; after reset, txn_count=0.
